// File: rtl/calculator_pkg.sv
// Shared calculator widths and the packer output-stage state type.
package calculator_pkg;

  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;
  localparam int LANES         = MEM_WORD_SIZE / DATA_W;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/pack_out_stage.sv
// One-entry output register for packed words; loads on close, word visible the next cycle.
// Backpressure: holds word/strb/addr while valid_o && !ready_i; reload while draining keeps it FULL.
module pack_out_stage
  import calculator_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int STRB_W = 2,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_word_i,
  input  logic [STRB_W-1:0] load_strb_i,
  input  logic              ready_i,
  output logic [WORD_W-1:0] word_o,
  output logic [STRB_W-1:0] strb_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              valid_o
);

  out_state_e state_q;
  out_state_e state_d;

  assign valid_o = (state_q == OUT_FULL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (load_i) state_d = OUT_FULL;
      OUT_FULL: begin
        if (load_i)       state_d = OUT_FULL;
        else if (ready_i) state_d = OUT_EMPTY;
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OUT_EMPTY;
      word_o  <= '0;
      strb_o  <= '0;
      addr_o  <= '0;
    end else begin
      state_q <= state_d;
      if (load_i) begin
        word_o <= load_word_i;
        strb_o <= load_strb_i;
      end
      // Address names the word currently presented; it moves on only after a handshake.
      if (valid_o && ready_i) addr_o <= addr_o + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/result_packer.sv
// Packs LANES ALU results into one memory word; closing accept to word_valid_o is 1 cycle.
// Backpressure: result_ready_o drops only when the last lane is due and the output stage cannot drain.
module result_packer #(
  parameter int DATA_W = calculator_pkg::DATA_W,
  parameter int LANES  = calculator_pkg::MEM_WORD_SIZE / DATA_W,
  parameter int ADDR_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_W-1:0]       result_i,
  input  logic                    result_valid_i,
  output logic                    result_ready_o,
  input  logic                    flush_i,
  output logic [DATA_W*LANES-1:0] word_o,
  output logic [LANES-1:0]        word_strb_o,
  output logic [ADDR_W-1:0]       word_addr_o,
  output logic                    word_valid_o,
  input  logic                    word_ready_i
);

  localparam int PTR_W  = $clog2(LANES);
  localparam int WORD_W = DATA_W * LANES;
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

  logic [PTR_W-1:0]  lane_ptr_q;
  logic [WORD_W-1:0] pack_q;
  logic [WORD_W-1:0] pack_merged;
  logic [LANES-1:0]  strb_q;
  logic [LANES-1:0]  strb_merged;
  logic              flush_pending_q;

  logic accept;
  logic at_last;
  logic out_can_take;
  logic flush_req;
  logic has_data;
  logic close;

  assign out_can_take   = !word_valid_o || word_ready_i;
  assign at_last        = (lane_ptr_q == LAST_LANE);
  assign result_ready_o = !at_last || out_can_take;
  assign accept         = result_valid_i && result_ready_o;
  assign flush_req      = flush_i || flush_pending_q;
  assign has_data       = (lane_ptr_q != '0) || accept;
  // A flush may only close once the output stage has room; a same-cycle accept joins the word.
  assign close          = (accept && at_last) || (flush_req && out_can_take && has_data);

  always_comb begin
    pack_merged = pack_q;
    strb_merged = strb_q;
    if (accept) begin
      pack_merged[int'(lane_ptr_q) * DATA_W +: DATA_W] = result_i;
      strb_merged[lane_ptr_q]                          = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_ptr_q      <= '0;
      pack_q          <= '0;
      strb_q          <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      if (close) begin
        lane_ptr_q <= '0;
        pack_q     <= '0;
        strb_q     <= '0;
      end else if (accept) begin
        lane_ptr_q <= lane_ptr_q + PTR_W'(1);
        pack_q     <= pack_merged;
        strb_q     <= strb_merged;
      end
      if (close || (flush_req && !has_data)) flush_pending_q <= 1'b0;
      else if (flush_i)                      flush_pending_q <= 1'b1;
    end
  end

  pack_out_stage #(
    .WORD_W (WORD_W),
    .STRB_W (LANES),
    .ADDR_W (ADDR_W)
  ) u_out (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (close),
    .load_word_i (pack_merged),
    .load_strb_i (strb_merged),
    .ready_i     (word_ready_i),
    .word_o      (word_o),
    .strb_o      (word_strb_o),
    .addr_o      (word_addr_o),
    .valid_o     (word_valid_o)
  );

endmodule

// File: tb/tb_result_packer.sv
// Directed and randomized checks of result_packer against a queue-based reference model.
module tb_result_packer;

  localparam int DW = 32;
  localparam int LN = 2;
  localparam int AW = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [DW-1:0]     result_i;
  logic              result_valid_i;
  logic              result_ready_o;
  logic              flush_i;
  logic [DW*LN-1:0]  word_o;
  logic [LN-1:0]     word_strb_o;
  logic [AW-1:0]     word_addr_o;
  logic              word_valid_o;
  logic              word_ready_i;

  int total  = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  result_packer #(.DATA_W(DW), .LANES(LN), .ADDR_W(AW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .result_i       (result_i),
    .result_valid_i (result_valid_i),
    .result_ready_o (result_ready_o),
    .flush_i        (flush_i),
    .word_o         (word_o),
    .word_strb_o    (word_strb_o),
    .word_addr_o    (word_addr_o),
    .word_valid_o   (word_valid_o),
    .word_ready_i   (word_ready_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic f, input logic wr);
    result_valid_i = v;
    result_i       = d;
    flush_i        = f;
    word_ready_i   = wr;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    tick();
    tick();
    rst_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    settle();
    total++; if (word_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", word_valid_o); else passed++;
    total++; if (word_o !== 64'h0) $display("FAIL rst_word: got %h want 0", word_o); else passed++;
    total++; if (word_strb_o !== 2'b00) $display("FAIL rst_strb: got %b want 00", word_strb_o); else passed++;
    total++; if (word_addr_o !== 8'h00) $display("FAIL rst_addr: got %h want 00", word_addr_o); else passed++;
    total++; if (result_ready_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", result_ready_o); else passed++;
    tick();
    settle();
    total++; if (word_valid_o !== 1'b0) $display("FAIL rst_no_word: got %b want 0", word_valid_o); else passed++;
    tick();
  endtask

  task automatic test_full_word();
    drive(1'b1, 32'h11111111, 1'b0, 1'b1);
    settle();
    total++; if (result_ready_o !== 1'b1) $display("FAIL full_rdy0: got %b want 1", result_ready_o); else passed++;
    tick();
    drive(1'b1, 32'h22222222, 1'b0, 1'b1);
    settle();
    total++; if (result_ready_o !== 1'b1) $display("FAIL full_rdy1: got %b want 1", result_ready_o); else passed++;
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    settle();
    total++; if (word_valid_o !== 1'b1) $display("FAIL full_valid: got %b want 1", word_valid_o); else passed++;
    total++; if (word_o !== 64'h22222222_11111111) $display("FAIL full_word: got %h want 2222222211111111", word_o); else passed++;
    total++; if (word_strb_o !== 2'b11) $display("FAIL full_strb: got %b want 11", word_strb_o); else passed++;
    total++; if (word_addr_o !== 8'h00) $display("FAIL full_addr: got %h want 00", word_addr_o); else passed++;
    tick();
    settle();
    total++; if (word_valid_o !== 1'b0) $display("FAIL full_one_cycle: got %b want 0", word_valid_o); else passed++;
    tick();
  endtask

  task automatic test_flush_partial();
    do_reset();
    drive(1'b1, 32'hAAAA0001, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    settle();
    total++; if (word_valid_o !== 1'b1) $display("FAIL flush_valid: got %b want 1", word_valid_o); else passed++;
    total++; if (word_o !== 64'h00000000_AAAA0001) $display("FAIL flush_word: got %h want 00000000AAAA0001", word_o); else passed++;
    total++; if (word_strb_o !== 2'b01) $display("FAIL flush_strb: got %b want 01", word_strb_o); else passed++;
    total++; if (word_addr_o !== 8'h00) $display("FAIL flush_addr: got %h want 00", word_addr_o); else passed++;
    tick();
    drive(1'b1, 32'h00000003, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h00000004, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    settle();
    total++; if (word_valid_o !== 1'b1) $display("FAIL flush_next_valid: got %b want 1", word_valid_o); else passed++;
    total++; if (word_addr_o !== 8'h01) $display("FAIL flush_next_addr: got %h want 01", word_addr_o); else passed++;
    total++; if (word_o !== 64'h00000004_00000003) $display("FAIL flush_next_word: got %h want 0000000400000003", word_o); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 32'hA0A0A0A0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hB0B0B0B0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hC0C0C0C0, 1'b0, 1'b0);
    settle();
    total++; if (result_ready_o !== 1'b1) $display("FAIL bp_lane0_rdy: got %b want 1", result_ready_o); else passed++;
    tick();
    drive(1'b1, 32'hD0D0D0D0, 1'b0, 1'b0);
    settle();
    total++; if (result_ready_o !== 1'b0) $display("FAIL bp_stall_rdy: got %b want 0", result_ready_o); else passed++;
    total++; if (word_o !== 64'hB0B0B0B0_A0A0A0A0) $display("FAIL bp_word: got %h want B0B0B0B0A0A0A0A0", word_o); else passed++;
    tick();
    settle();
    total++; if (word_o !== 64'hB0B0B0B0_A0A0A0A0) $display("FAIL bp_word_held: got %h want B0B0B0B0A0A0A0A0", word_o); else passed++;
    total++; if (word_valid_o !== 1'b1) $display("FAIL bp_valid_held: got %b want 1", word_valid_o); else passed++;
    word_ready_i = 1'b1;
    #1;
    total++; if (result_ready_o !== 1'b1) $display("FAIL bp_release_rdy: got %b want 1", result_ready_o); else passed++;
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    settle();
    total++; if (word_valid_o !== 1'b1) $display("FAIL bp_b2b_valid: got %b want 1", word_valid_o); else passed++;
    total++; if (word_o !== 64'hD0D0D0D0_C0C0C0C0) $display("FAIL bp_b2b_word: got %h want D0D0D0D0C0C0C0C0", word_o); else passed++;
    total++; if (word_addr_o !== 8'h01) $display("FAIL bp_b2b_addr: got %h want 01", word_addr_o); else passed++;
    tick();
    word_ready_i = 1'b1;
    tick();
    settle();
    total++; if (word_valid_o !== 1'b0) $display("FAIL bp_drained: got %b want 0", word_valid_o); else passed++;
    tick();
  endtask

  task automatic test_addr_wrap();
    int wcnt = 0;
    do_reset();
    for (int i = 0; i < 2 * 257 + 3; i++) begin
      if (i < 2 * 257) drive(1'b1, DW'(i), 1'b0, 1'b1);
      else             drive(1'b0, '0, 1'b0, 1'b1);
      settle();
      if (word_valid_o === 1'b1) begin
        total++; if (word_addr_o !== AW'(wcnt)) $display("FAIL wrap_addr: word %0d got %h want %h", wcnt, word_addr_o, AW'(wcnt)); else passed++;
        total++; if (word_o !== {DW'(2 * wcnt + 1), DW'(2 * wcnt)}) $display("FAIL wrap_word: word %0d got %h", wcnt, word_o); else passed++;
        if (wcnt == 256) begin
          total++; if (word_addr_o !== 8'h00) $display("FAIL wrap_257th_addr: got %h want 00", word_addr_o); else passed++;
        end
        wcnt++;
      end
      tick();
    end
    total++; if (wcnt != 257) $display("FAIL wrap_count: got %0d want 257", wcnt); else passed++;
  endtask

  task automatic test_flush_edge();
    do_reset();
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      settle();
      total++; if (word_valid_o !== 1'b0) $display("FAIL noop_flush_word: cycle %0d got %b want 0", i, word_valid_o); else passed++;
      tick();
    end
    drive(1'b1, 32'hE0E0E0E0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'hF0F0F0F0, 1'b1, 1'b1);
    settle();
    total++; if (word_valid_o !== 1'b0) $display("FAIL noop_pending_cleared: got %b want 0", word_valid_o); else passed++;
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    settle();
    total++; if (word_valid_o !== 1'b1) $display("FAIL flush_acc_valid: got %b want 1", word_valid_o); else passed++;
    total++; if (word_o !== 64'hF0F0F0F0_E0E0E0E0) $display("FAIL flush_acc_word: got %h want F0F0F0F0E0E0E0E0", word_o); else passed++;
    total++; if (word_strb_o !== 2'b11) $display("FAIL flush_acc_strb: got %b want 11", word_strb_o); else passed++;
    tick();
    settle();
    total++; if (word_valid_o !== 1'b0) $display("FAIL flush_acc_single: got %b want 0", word_valid_o); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 32'h01010101, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h02020202, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h03030303, 1'b0, 1'b0);
    tick();
    rst_i = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    rst_i = 1'b0;
    settle();
    total++; if (word_valid_o !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", word_valid_o); else passed++;
    total++; if (word_o !== 64'h0) $display("FAIL mid_rst_word: got %h want 0", word_o); else passed++;
    total++; if (word_strb_o !== 2'b00) $display("FAIL mid_rst_strb: got %b want 00", word_strb_o); else passed++;
    total++; if (word_addr_o !== 8'h00) $display("FAIL mid_rst_addr: got %h want 00", word_addr_o); else passed++;
    total++; if (result_ready_o !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", result_ready_o); else passed++;
    tick();
    drive(1'b1, 32'h0000AAAA, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h0000BBBB, 1'b0, 1'b1);
    settle();
    total++; if (word_valid_o !== 1'b0) $display("FAIL mid_rst_one_accept: got %b want 0", word_valid_o); else passed++;
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    settle();
    total++; if (word_valid_o !== 1'b1) $display("FAIL mid_rst_new_valid: got %b want 1", word_valid_o); else passed++;
    total++; if (word_o !== 64'h0000BBBB_0000AAAA) $display("FAIL mid_rst_new_word: got %h want 0000BBBB0000AAAA", word_o); else passed++;
    total++; if (word_addr_o !== 8'h00) $display("FAIL mid_rst_new_addr: got %h want 00", word_addr_o); else passed++;
    tick();
  endtask

  // Reference: results queue up until LANES arrive or a flush finds the output slot free.
  task automatic test_random();
    logic [DW-1:0]    part[$];
    logic [DW-1:0]    nxt[$];
    logic             mvalid = 1'b0;
    logic [DW*LN-1:0] mword  = '0;
    logic [LN-1:0]    mstrb  = '0;
    logic [AW-1:0]    maddr  = '0;
    logic             mflush = 1'b0;
    logic v, f, wr, exp_rdy, acc, can_take, freq, cls;
    logic [DW-1:0] d;
    do_reset();
    part.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v  = ($urandom_range(0, 9) < 7);
      f  = ($urandom_range(0, 9) == 0);
      wr = ($urandom_range(0, 9) < 6);
      d  = $urandom;
      drive(v, d, f, wr);
      settle();
      exp_rdy = (part.size() != LN - 1) || !mvalid || wr;
      total++; if (result_ready_o !== exp_rdy) $display("FAIL rnd_ready: cyc %0d got %b want %b", cyc, result_ready_o, exp_rdy); else passed++;
      total++; if (word_valid_o !== mvalid) $display("FAIL rnd_valid: cyc %0d got %b want %b", cyc, word_valid_o, mvalid); else passed++;
      if (mvalid) begin
        total++; if (word_o !== mword) $display("FAIL rnd_word: cyc %0d got %h want %h", cyc, word_o, mword); else passed++;
        total++; if (word_strb_o !== mstrb) $display("FAIL rnd_strb: cyc %0d got %b want %b", cyc, word_strb_o, mstrb); else passed++;
        total++; if (word_addr_o !== maddr) $display("FAIL rnd_addr: cyc %0d got %h want %h", cyc, word_addr_o, maddr); else passed++;
      end
      acc      = v && exp_rdy;
      can_take = !mvalid || wr;
      freq     = f || mflush;
      nxt      = part;
      if (acc) nxt.push_back(d);
      cls = (nxt.size() == LN) || (freq && can_take && nxt.size() > 0);
      if (mvalid && wr) begin
        maddr  = maddr + 1'b1;
        mvalid = 1'b0;
      end
      if (cls) begin
        mword = '0;
        for (int k = 0; k < nxt.size(); k++) mword[k * DW +: DW] = nxt[k];
        mstrb  = LN'((1 << nxt.size()) - 1);
        mvalid = 1'b1;
        part.delete();
      end else begin
        part = nxt;
      end
      if (freq && (cls || nxt.size() == 0)) mflush = 1'b0;
      else if (freq)                         mflush = 1'b1;
      tick();
    end
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_full_word();
    test_flush_partial();
    test_backpressure();
    test_addr_wrap();
    test_flush_edge();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
